// File: rtl/regfile_write_arbiter_if.sv
// Write-request and register-file-port bundle between the two writers and the write arbiter.
// The master side is the writer/consumer side; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                     reqAValid;
  logic                     reqAReady;
  logic [DATA_WIDTH-1:0]    reqAData;
  logic [ADDR_WIDTH-1:0]    reqAReg;
  logic                     reqBValid;
  logic                     reqBReady;
  logic [DATA_WIDTH-1:0]    reqBData;
  logic [ADDR_WIDTH-1:0]    reqBReg;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic [ADDR_WIDTH-1:0]    dataInRegister;
  logic                     enableSavingDataIn;
  logic [2**ADDR_WIDTH-1:0] pendingMask;
  logic                     lastGrantB;

  modport master (
    output reqAValid, reqAData, reqAReg,
    output reqBValid, reqBData, reqBReg,
    input  reqAReady, reqBReady,
    input  dataIn, dataInRegister, enableSavingDataIn, pendingMask, lastGrantB
  );

  modport slave (
    input  reqAValid, reqAData, reqAReg,
    input  reqBValid, reqBData, reqBReg,
    output reqAReady, reqBReady,
    output dataIn, dataInRegister, enableSavingDataIn, pendingMask, lastGrantB
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writers A and B, each behind a
// one-entry buffer; round-robin, except same-register writes retire in arrival order.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic                   clk,
  input logic                   resetN,
  regfile_write_arbiter_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  bufAValid;
  logic [DATA_WIDTH-1:0] bufAData;
  logic [ADDR_WIDTH-1:0] bufAReg;
  logic                  bufBValid;
  logic [DATA_WIDTH-1:0] bufBData;
  logic [ADDR_WIDTH-1:0] bufBReg;
  logic                  aOlder;
  logic                  lastGrantBQ;
  logic                  enableQ;
  logic [DATA_WIDTH-1:0] dataInQ;
  logic [ADDR_WIDTH-1:0] dataInRegQ;

  logic                  grantA;
  logic                  grantB;
  logic                  readyA;
  logic                  readyB;
  logic                  acceptA;
  logic                  acceptB;
  logic [NUM_REGS-1:0]   pendingMask;

  // Same-register pairs go by age so the later write to a register always lands last.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (bufAValid && bufBValid) begin
      if (bufAReg == bufBReg) begin
        grantA = aOlder;
        grantB = !aOlder;
      end else begin
        grantA = lastGrantBQ;
        grantB = !lastGrantBQ;
      end
    end else begin
      grantA = bufAValid;
      grantB = bufBValid;
    end
  end

  assign readyA  = !bufAValid || grantA;
  assign readyB  = !bufBValid || grantB;
  assign acceptA = bus.reqAValid && readyA;
  assign acceptB = bus.reqBValid && readyB;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      bufAValid   <= 1'b0;
      bufAData    <= '0;
      bufAReg     <= '0;
      bufBValid   <= 1'b0;
      bufBData    <= '0;
      bufBReg     <= '0;
      aOlder      <= 1'b1;
      lastGrantBQ <= 1'b1;
      enableQ     <= 1'b0;
      dataInQ     <= '0;
      dataInRegQ  <= '0;
    end else begin
      if (acceptA) begin
        bufAValid <= 1'b1;
        bufAData  <= bus.reqAData;
        bufAReg   <= bus.reqAReg;
      end else if (grantA) begin
        bufAValid <= 1'b0;
      end

      if (acceptB) begin
        bufBValid <= 1'b1;
        bufBData  <= bus.reqBData;
        bufBReg   <= bus.reqBReg;
      end else if (grantB) begin
        bufBValid <= 1'b0;
      end

      // A newcomer is younger than an entry that stays behind; a tie counts A as older.
      if (acceptA && acceptB) begin
        aOlder <= 1'b1;
      end else if (acceptA && bufBValid && !grantB) begin
        aOlder <= 1'b0;
      end else if (acceptB && bufAValid && !grantA) begin
        aOlder <= 1'b1;
      end

      if (grantA || grantB) begin
        enableQ     <= 1'b1;
        dataInQ     <= grantA ? bufAData : bufBData;
        dataInRegQ  <= grantA ? bufAReg : bufBReg;
        lastGrantBQ <= grantB;
      end else begin
        enableQ <= 1'b0;
      end
    end
  end

  always_comb begin
    pendingMask = '0;
    if (bufAValid) pendingMask[bufAReg] = 1'b1;
    if (bufBValid) pendingMask[bufBReg] = 1'b1;
    if (enableQ)   pendingMask[dataInRegQ] = 1'b1;
  end

  assign bus.reqAReady          = readyA;
  assign bus.reqBReady          = readyB;
  assign bus.dataIn             = dataInQ;
  assign bus.dataInRegister     = dataInRegQ;
  assign bus.enableSavingDataIn = enableQ;
  assign bus.pendingMask        = pendingMask;
  assign bus.lastGrantB         = lastGrantBQ;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic against a
// stamp-ordered reference model with per-register pending counts and last-write tracking.
module tb_regfile_write_arbiter;
  logic clk;
  logic resetN;

  regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Register file image built from the write port, plus a running count of writes.
  logic [31:0] rf [16];
  int          issued = 0;
  always @(posedge clk) begin
    if (bus.enableSavingDataIn === 1'b1) begin
      rf[bus.dataInRegister] <= bus.dataIn;
      issued <= issued + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] ad;
    logic [3:0]  ar;
    logic        bv;
    logic [31:0] bd;
    logic [3:0]  br;
    logic        chk;
    logic        ra;
    logic        rb;
    logic        en;
    logic        cd;
    logic [31:0] d;
    logic [3:0]  r;
    logic [15:0] mask;
    logic        lastB;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic rst, logic av, logic [31:0] ad, logic [3:0] ar,
                              logic bv, logic [31:0] bd, logic [3:0] br, logic chk,
                              logic ra, logic rb, logic en, logic cd, logic [31:0] d,
                              logic [3:0] r, logic [15:0] mask, logic lastB);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.ar = ar; v.bv = bv; v.bd = bd; v.br = br;
    v.chk = chk; v.ra = ra; v.rb = rb; v.en = en; v.cd = cd; v.d = d; v.r = r;
    v.mask = mask; v.lastB = lastB;
    return v;
  endfunction

  typedef struct {
    bit          v;
    logic [31:0] d;
    logic [3:0]  r;
    int unsigned stamp;
  } mbuf_t;

  mbuf_t       mA, mB;
  bit          mLastB;
  bit          mEn;
  logic [31:0] mD;
  logic [3:0]  mR;
  int          pend [16];
  logic [31:0] lastAcc [16];
  bit          everAcc [16];
  int unsigned seqNo;
  int          accepted;

  function automatic void modelGrant(output bit gA, output bit gB);
    gA = 1'b0;
    gB = 1'b0;
    if (mA.v && mB.v) begin
      if (mA.r == mB.r) gA = (mA.stamp < mB.stamp);
      else              gA = mLastB;
      gB = !gA;
    end else begin
      gA = mA.v;
      gB = mB.v;
    end
  endfunction

  initial begin
    bit          gA, gB, accA, accB, holdA, holdB;
    logic [15:0] expMask;
    int          issuedStart;

    resetN = 1'b0;
    bus.reqAValid = 1'b0; bus.reqAData = '0; bus.reqAReg = '0;
    bus.reqBValid = 1'b0; bus.reqBData = '0; bus.reqBReg = '0;

    // Reset with A requesting, then release
    vecs.push_back(mk(0,1,32'hDEAD,2, 0,0,0, 0, 0,0,0,0,0,0,16'h0000,0));
    vecs.push_back(mk(0,1,32'hDEAD,2, 0,0,0, 1, 1,1,0,0,0,0,16'h0000,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0, 1, 1,1,0,1,0,0,16'h0000,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0, 1, 1,1,0,1,0,0,16'h0000,1));
    // Lone writer A streams r3,r4,r5
    vecs.push_back(mk(1,1,32'h11,3,  0,0,0, 1, 1,1,0,0,0,0,16'h0000,1));
    vecs.push_back(mk(1,1,32'h22,4,  0,0,0, 1, 1,1,0,0,0,0,16'h0008,1));
    vecs.push_back(mk(1,1,32'h33,5,  0,0,0, 1, 1,1,1,1,32'h11,3,16'h0018,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0, 1, 1,1,1,1,32'h22,4,16'h0030,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0, 1, 1,1,1,1,32'h33,5,16'h0020,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0, 1, 1,1,0,1,32'h33,5,16'h0000,0));
    // Contention on different registers: grants alternate
    vecs.push_back(mk(1,1,32'hA,1,   1,32'hB,2, 1, 1,1,0,0,0,0,16'h0000,0));
    vecs.push_back(mk(1,1,32'hA,1,   1,32'hB,2, 1, 0,1,0,0,0,0,16'h0006,0));
    vecs.push_back(mk(1,1,32'hA,1,   1,32'hB,2, 1, 1,0,1,1,32'hB,2,16'h0006,1));
    vecs.push_back(mk(1,1,32'hA,1,   1,32'hB,2, 1, 0,1,1,1,32'hA,1,16'h0006,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,0,1,1,32'hB,2,16'h0006,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'hA,1,16'h0006,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'hB,2,16'h0004,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,0,0,0,0,16'h0000,1));
    // Same register r7: B first, then A
    vecs.push_back(mk(1,0,0,0,       1,32'h1,7, 1, 1,1,0,0,0,0,16'h0000,1));
    vecs.push_back(mk(1,1,32'h2,7,   0,0,0,     1, 1,1,0,0,0,0,16'h0080,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'h1,7,16'h0080,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'h2,7,16'h0080,0));
    // Same register r9 accepted together while round-robin favours B: A still goes first
    vecs.push_back(mk(1,1,32'h5,9,   1,32'h6,9, 1, 1,1,0,0,0,0,16'h0000,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,0,0,0,0,0,16'h0200,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'h5,9,16'h0200,0));
    vecs.push_back(mk(1,0,0,0,       0,0,0,     1, 1,1,1,1,32'h6,9,16'h0200,1));
    // Reset with both buffers full discards them
    vecs.push_back(mk(1,1,32'h77,10, 1,32'h88,11, 1, 1,1,0,0,0,0,16'h0000,1));
    vecs.push_back(mk(0,0,0,0,       0,0,0,       1, 1,0,0,0,0,0,16'h0C00,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,       1, 1,1,0,1,0,0,16'h0000,1));
    vecs.push_back(mk(1,0,0,0,       0,0,0,       1, 1,1,0,1,0,0,16'h0000,1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetN        = vecs[i].rst;
      bus.reqAValid = vecs[i].av; bus.reqAData = vecs[i].ad; bus.reqAReg = vecs[i].ar;
      bus.reqBValid = vecs[i].bv; bus.reqBData = vecs[i].bd; bus.reqBReg = vecs[i].br;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d reqAReady", i), bus.reqAReady, vecs[i].ra);
        check($sformatf("vec%0d reqBReady", i), bus.reqBReady, vecs[i].rb);
        check($sformatf("vec%0d enable", i), bus.enableSavingDataIn, vecs[i].en);
        check($sformatf("vec%0d pendingMask", i), bus.pendingMask, vecs[i].mask);
        check($sformatf("vec%0d lastGrantB", i), bus.lastGrantB, vecs[i].lastB);
        if (vecs[i].cd) begin
          check($sformatf("vec%0d dataIn", i), bus.dataIn, vecs[i].d);
          check($sformatf("vec%0d dataInRegister", i), bus.dataInRegister, vecs[i].r);
        end
      end
    end

    check("rf r3", rf[3], 32'h11);
    check("rf r4", rf[4], 32'h22);
    check("rf r5", rf[5], 32'h33);
    check("rf r1", rf[1], 32'hA);
    check("rf r2", rf[2], 32'hB);
    check("rf r7", rf[7], 32'h2);
    check("rf r9", rf[9], 32'h6);

    // Random traffic; DUT is in its reset state here
    mA = '{default: 0}; mB = '{default: 0};
    mLastB = 1'b1; mEn = 1'b0; mD = '0; mR = '0;
    seqNo = 0; accepted = 0;
    for (int r = 0; r < 16; r++) begin
      pend[r] = 0; lastAcc[r] = '0; everAcc[r] = 1'b0;
    end
    holdA = 1'b0; holdB = 1'b0;
    issuedStart = issued;

    for (int cyc = 0; cyc < 410; cyc++) begin
      @(negedge clk);
      modelGrant(gA, gB);
      expMask = '0;
      for (int r = 0; r < 16; r++) if (pend[r] != 0) expMask[r] = 1'b1;
      check($sformatf("rnd%0d reqAReady", cyc), bus.reqAReady, !mA.v || gA);
      check($sformatf("rnd%0d reqBReady", cyc), bus.reqBReady, !mB.v || gB);
      check($sformatf("rnd%0d enable", cyc), bus.enableSavingDataIn, mEn);
      check($sformatf("rnd%0d dataIn", cyc), bus.dataIn, mD);
      check($sformatf("rnd%0d dataInRegister", cyc), bus.dataInRegister, mR);
      check($sformatf("rnd%0d pendingMask", cyc), bus.pendingMask, expMask);
      check($sformatf("rnd%0d lastGrantB", cyc), bus.lastGrantB, mLastB);

      // Stalled writers keep their request; the last 10 cycles drain
      if (!holdA) begin
        bus.reqAValid = (cyc < 400) && ($urandom_range(0, 99) < 65);
        bus.reqAData  = $urandom;
        bus.reqAReg   = 4'($urandom_range(0, 3));
      end
      if (!holdB) begin
        bus.reqBValid = (cyc < 400) && ($urandom_range(0, 99) < 65);
        bus.reqBData  = $urandom;
        bus.reqBReg   = 4'($urandom_range(0, 3));
      end

      accA = bus.reqAValid && (!mA.v || gA);
      accB = bus.reqBValid && (!mB.v || gB);
      holdA = bus.reqAValid && !accA;
      holdB = bus.reqBValid && !accB;

      if (mEn) pend[mR]--;
      if (gA || gB) begin
        mEn    = 1'b1;
        mD     = gA ? mA.d : mB.d;
        mR     = gA ? mA.r : mB.r;
        mLastB = gB;
      end else begin
        mEn = 1'b0;
      end
      if (gA) mA.v = 1'b0;
      if (gB) mB.v = 1'b0;
      if (accA) begin
        mA = '{1'b1, bus.reqAData, bus.reqAReg, seqNo};
        seqNo++;
        pend[bus.reqAReg]++;
        lastAcc[bus.reqAReg] = bus.reqAData;
        everAcc[bus.reqAReg] = 1'b1;
        accepted++;
      end
      if (accB) begin
        mB = '{1'b1, bus.reqBData, bus.reqBReg, seqNo};
        seqNo++;
        pend[bus.reqBReg]++;
        lastAcc[bus.reqBReg] = bus.reqBData;
        everAcc[bus.reqBReg] = 1'b1;
        accepted++;
      end
    end

    @(negedge clk);
    check("rnd write count", issued - issuedStart, accepted);
    for (int r = 0; r < 4; r++) begin
      if (everAcc[r]) check($sformatf("rnd final r%0d", r), rf[r], lastAcc[r]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x32 register file between two writers: A (pipeline writeback) and B (load/debug unit).
- Each writer has a valid/ready handshake into a one-entry holding buffer.
- Arbitration is round-robin, except that writes to the same register always retire in arrival order.
- Drives the register file's dataIn/dataInRegister/enableSavingDataIn from registers, and exports a pending-write mask so the issue logic can stall reads of registers with writes in flight.

Parameters:
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 4, register index width (2**ADDR_WIDTH registers)

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetN  input  1  synchronous active-low reset
- reqAValid  input  1  writer A has a write
- reqAReady  output  1  writer A write accepted this cycle when valid&ready
- reqAData  input  DATA_WIDTH  writer A data
- reqAReg  input  ADDR_WIDTH  writer A destination register
- reqBValid  input  1  writer B has a write
- reqBReady  output  1  writer B handshake ready
- reqBData  input  DATA_WIDTH  writer B data
- reqBReg  input  ADDR_WIDTH  writer B destination register
- dataIn  output  DATA_WIDTH  to register file write data
- dataInRegister  output  ADDR_WIDTH  to register file write index
- enableSavingDataIn  output  1  to register file write enable
- pendingMask  output  2**ADDR_WIDTH  bit r set = write to register r accepted but not yet performed
- lastGrantB  output  1  1 = most recent grant went to B

Behaviour:
- Reset (resetN=0 at a rising edge):
  - both buffers empty; enableSavingDataIn=0, dataIn=0, dataInRegister=0.
  - lastGrantB=1 (A wins the first contested round-robin); age bit aOlder=1.
  - Reset overrides any handshake in the same cycle. Writes buffered but not yet issued are discarded.
- Buffers: bufX holds {valid, data, reg}, one per writer.
  - reqXReady = !bufXValid | grantX. Combinational from registers only; never depends on reqXValid.
  - Accept when reqXValid & reqXReady: the buffer loads at the edge. A same-edge grant and reload is legal.
- Grant (combinational from buffer state, registered into outputs):
  - only bufA valid -> grantA; only bufB valid -> grantB.
  - both valid, different regs -> round-robin: grantA if lastGrantB=1, else grantB.
  - both valid, same reg -> grant the older one (aOlder ? A : B). Round-robin is not consulted, but lastGrantB still updates.
- Age bit aOlder, updated at the edge:
  - A loads while B stays valid and is not granted -> 0.
  - B loads while A stays valid and is not granted -> 1.
  - Both load on the same edge -> 1 (A is treated as older).
  - Otherwise unchanged.
- Output stage, at the edge after a grant:
  - enableSavingDataIn=1; dataIn/dataInRegister = granted buffer contents; granted buffer cleared unless reloaded.
  - No grant -> enableSavingDataIn=0; dataIn/dataInRegister hold their previous values.
- Latency: accepted at edge N -> enableSavingDataIn high during cycle N+1 at the earliest -> register file updated at edge N+2.
- Throughput: one write per cycle total. A lone writer sustains 1 write/cycle.
- pendingMask = decode(bufA) | decode(bufB) | (enableSavingDataIn ? decode(dataInRegister) : 0).
  - A bit clears in the cycle after the register file edge that commits the write.
- Same-register, same-cycle reads: the register file returns the old value. Consumers must check pendingMask; this block does no forwarding.
- No write is ever dropped or duplicated. A stalled writer holds valid and data stable until ready.

Test Plan:
- Reset: hold resetN=0 two cycles with reqAValid=1 -> reqAReady=1, enableSavingDataIn=0, pendingMask=0, lastGrantB=1; no write issued after reset release from pre-reset data.
- Lone writer streaming: A sends r3=0x11, r4=0x22, r5=0x33 on consecutive cycles -> reqAReady stays 1; enableSavingDataIn high 3 consecutive cycles with regs 3,4,5 in order; pendingMask bit 3 set one cycle after accept, cleared after commit.
- Contention, different regs: A (r1=0xA) and B (r2=0xB) both valid every cycle -> grants alternate A,B,A,B; each writer sees ready every other cycle.
- Same register ordering, B first: B writes r7=0x1 at edge N, A writes r7=0x2 at edge N+1 while lastGrantB=1 -> B's 0x1 issued before A's 0x2; final r7=0x2.
- Same register, simultaneous accept: A r9=0x5, B r9=0x6 accepted on the same edge -> A issued first, then B; final r9=0x6.
- Reset mid-operation: both buffers full, then resetN=0 for one cycle -> buffers cleared, pendingMask=0, no write issued from discarded entries.
